// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request load/store sequencer between the CPU datapath and a synchronous RAM
//
// Ports:
//   i_clk, i_reset            clock (rising edge), asynchronous active-high reset
//   i_cpu_req_*               request: valid/ready handshake, write flag, word address, store data
//   o_cpu_resp_*              one-cycle completion pulse, store flag, load data (held until next load)
//   o_ram_address/data_in     RAM address and write data, always driven from the latched request
//   o_ram_write_enable        RAM write strobe, high for the single ISSUE cycle of a store
//   o_ram_read_enable         RAM read strobe, high for the single ISSUE cycle of a load
//   i_ram_data_out            RAM read data, valid RAM_READ_LATENCY cycles after the read-enable edge

module mem_access_ctrl #(
    parameter int ADDR_WIDTH       = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_req_valid,
    output logic                  o_cpu_req_ready,
    input  logic                  i_cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] i_cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_req_wdata,
    output logic                  o_cpu_resp_valid,
    output logic                  o_cpu_resp_write,
    output logic [DATA_WIDTH-1:0] o_cpu_resp_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data_in,
    output logic                  o_ram_write_enable,
    output logic                  o_ram_read_enable,
    input  logic [DATA_WIDTH-1:0] i_ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter preload: the WAIT state is entered one cycle after the enable
    // edge, so it spends RAM_READ_LATENCY cycles there before capturing.
    localparam logic [2:0] LAT_M1 = 3'(RAM_READ_LATENCY - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic [2:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_wait_cnt <= 3'd0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Request fields are sampled only here; the requester may
                    // change them freely once the transfer edge has passed.
                    if (i_cpu_req_valid) begin
                        r_addr  <= i_cpu_req_addr;
                        r_wdata <= i_cpu_req_wdata;
                        r_write <= i_cpu_req_write;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_write) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= LAT_M1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_rdata <= i_ram_data_out;
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All control outputs decode straight from the state register, so an
    // asynchronous reset drops the RAM enables without waiting for an edge.
    assign o_cpu_req_ready    = (r_state == S_IDLE);
    assign o_cpu_resp_valid   = (r_state == S_RESP);
    assign o_cpu_resp_write   = (r_state == S_RESP) && r_write;
    assign o_cpu_resp_rdata   = r_rdata;
    assign o_ram_address      = r_addr;
    assign o_ram_data_in      = r_wdata;
    assign o_ram_write_enable = (r_state == S_ISSUE) && r_write;
    assign o_ram_read_enable  = (r_state == S_ISSUE) && !r_write;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl at read latency 1 and 3

module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RAM_READ_LATENCY = 1
    logic        a_rst, a_valid, a_ready, a_write;
    logic [7:0]  a_addr, a_ram_addr;
    logic [31:0] a_wdata, a_rdata, a_ram_din, a_dout;
    logic        a_resp_valid, a_resp_write, a_we, a_re;

    // DUT B: RAM_READ_LATENCY = 3
    logic        b_rst, b_valid, b_ready, b_write;
    logic [7:0]  b_addr, b_ram_addr;
    logic [31:0] b_wdata, b_rdata, b_ram_din, b_dout;
    logic        b_resp_valid, b_resp_write, b_we, b_re;

    mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_READ_LATENCY(1)) u_dut_a (
        .i_clk(clk), .i_reset(a_rst),
        .i_cpu_req_valid(a_valid), .o_cpu_req_ready(a_ready), .i_cpu_req_write(a_write),
        .i_cpu_req_addr(a_addr), .i_cpu_req_wdata(a_wdata),
        .o_cpu_resp_valid(a_resp_valid), .o_cpu_resp_write(a_resp_write), .o_cpu_resp_rdata(a_rdata),
        .o_ram_address(a_ram_addr), .o_ram_data_in(a_ram_din),
        .o_ram_write_enable(a_we), .o_ram_read_enable(a_re), .i_ram_data_out(a_dout)
    );

    mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_READ_LATENCY(3)) u_dut_b (
        .i_clk(clk), .i_reset(b_rst),
        .i_cpu_req_valid(b_valid), .o_cpu_req_ready(b_ready), .i_cpu_req_write(b_write),
        .i_cpu_req_addr(b_addr), .i_cpu_req_wdata(b_wdata),
        .o_cpu_resp_valid(b_resp_valid), .o_cpu_resp_write(b_resp_write), .o_cpu_resp_rdata(b_rdata),
        .o_ram_address(b_ram_addr), .o_ram_data_in(b_ram_din),
        .o_ram_write_enable(b_we), .o_ram_read_enable(b_re), .i_ram_data_out(b_dout)
    );

    // RAM models: registered read data is present only for the one cycle
    // exactly RAM_READ_LATENCY edges after the enable, zero otherwise.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    int we_cnt_a = 0;
    int re_cnt_a = 0;

    always @(posedge clk) begin
        if (a_we) mem_a[a_ram_addr] <= a_ram_din;
        pipe_a <= a_re ? mem_a[a_ram_addr] : 32'h0;
        if (a_we) we_cnt_a <= we_cnt_a + 1;
        if (a_re) re_cnt_a <= re_cnt_a + 1;
    end
    assign a_dout = pipe_a;

    always @(posedge clk) begin
        if (b_we) mem_b[b_ram_addr] <= b_ram_din;
        pipe_b[0] <= b_re ? mem_b[b_ram_addr] : 32'h0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_dout = pipe_b[2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 32'h0;
            mem_b[i] <= 32'h0;
        end
        mem_a[8'h54] <= 32'h0000_0097;
        mem_a[8'hFF] <= 32'hCAFE_F00D;
        mem_b[8'h54] <= 32'h0000_0097;
        mem_b[8'h92] <= 32'h0000_0046;
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input bit sel, input logic v, input logic w,
                         input logic [7:0] ad, input logic [31:0] d);
        if (sel) begin
            b_valid = v; b_write = w; b_addr = ad; b_wdata = d;
        end else begin
            a_valid = v; a_write = w; a_addr = ad; a_wdata = d;
        end
    endtask

    // One complete transaction. Latency is counted in cycles from the accept
    // edge to the cycle in which resp_valid is seen. With noise set, valid
    // stays high and the request fields wander while the controller is busy.
    task automatic txn(input bit sel, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input bit noise, input int exp_lat,
                       input logic [31:0] exp_rdata, input string tag);
        int n, en_n, bad;
        bit got;
        logic rdy, rv, rw, we, re;
        logic [7:0] ra;
        logic [31:0] rd, din;
        rdy = sel ? b_ready : a_ready;
        chk({tag, "_ready_before"}, rdy, 1);
        drive(sel, 1'b1, wr, addr, wdata);
        @(negedge clk);
        n = 1; en_n = 0; bad = 0; got = 0;
        while (n <= 20 && !got) begin
            if (noise) drive(sel, 1'b1, ~wr, addr ^ 8'(n * 7 + 1), wdata ^ 32'(n * 32'h0101_0101));
            else       drive(sel, 1'b0, 1'b0, 8'h00, 32'h0);
            rdy = sel ? b_ready      : a_ready;
            rv  = sel ? b_resp_valid : a_resp_valid;
            we  = sel ? b_we         : a_we;
            re  = sel ? b_re         : a_re;
            ra  = sel ? b_ram_addr   : a_ram_addr;
            din = sel ? b_ram_din    : a_ram_din;
            if (ra !== addr) bad++;
            if (wr ? re : we) bad++;
            if (wr ? we : re) begin
                en_n++;
                if (wr && din !== wdata) bad++;
            end
            if (rv) got = 1;
            else begin
                if (rdy) bad++;
                n++;
                @(negedge clk);
            end
        end
        drive(sel, 1'b0, 1'b0, 8'h00, 32'h0);
        rw = sel ? b_resp_write : a_resp_write;
        rd = sel ? b_rdata      : a_rdata;
        chk({tag, "_resp_seen"},   got, 1);
        chk({tag, "_latency"},     n, exp_lat);
        chk({tag, "_resp_write"},  rw, wr);
        chk({tag, "_rdata"},       rd, exp_rdata);
        chk({tag, "_enable_cycles"}, en_n, 1);
        chk({tag, "_busy_errors"}, bad, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, sel ? b_ready : a_ready, 1);
        chk({tag, "_resp_drop"},   sel ? b_resp_valid : a_resp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, we0, re0, cnt;
        a_rst = 1'b1; b_rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",      a_ready, 1);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_we",         a_we, 0);
        chk("rst_re",         a_re, 0);
        chk("rst_rdata",      a_rdata, 32'h0);
        chk("rst_ram_addr",   a_ram_addr, 8'h00);
        a_rst = 1'b0; b_rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!a_ready || a_resp_valid || a_we || a_re) bad++;
        end
        chk("idle_10_cycles", bad, 0);

        txn(0, 1'b0, 8'h54, 32'h0, 0, 3, 32'h0000_0097, "ld54");
        txn(0, 1'b1, 8'h92, 32'h1234_5678, 0, 2, 32'h0000_0097, "st92");
        chk("st92_mem", mem_a[8'h92], 32'h1234_5678);
        txn(0, 1'b0, 8'h92, 32'h0, 0, 3, 32'h1234_5678, "ld92");
        txn(0, 1'b0, 8'hFF, 32'h0, 0, 3, 32'hCAFE_F00D, "ldFF");

        we0 = we_cnt_a; re0 = re_cnt_a;
        txn(0, 1'b1, 8'h30, 32'hAAAA_0001, 1, 2, 32'hCAFE_F00D, "st30_busy");
        chk("st30_busy_writes", we_cnt_a - we0, 1);
        chk("st30_busy_reads",  re_cnt_a - re0, 0);
        chk("st30_busy_mem",    mem_a[8'h30], 32'hAAAA_0001);
        we0 = we_cnt_a; re0 = re_cnt_a;
        txn(0, 1'b0, 8'h30, 32'h0, 1, 3, 32'hAAAA_0001, "ld30_busy");
        chk("ld30_busy_writes", we_cnt_a - we0, 0);
        chk("ld30_busy_reads",  re_cnt_a - re0, 1);

        txn(1, 1'b0, 8'h54, 32'h0, 0, 5, 32'h0000_0097, "lat3_ld54");

        // Store cut off by reset in ISSUE, before its write edge.
        drive(1, 1'b1, 1'b1, 8'h92, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rst_issue_we_before", b_we, 1);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        b_rst = 1'b1;
        #1;
        chk("rst_issue_we",    b_we, 0);
        chk("rst_issue_re",    b_re, 0);
        chk("rst_issue_ready", b_ready, 1);
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        chk("rst_issue_mem92", mem_b[8'h92], 32'h0000_0046);

        // Load cut off by reset in WAIT: no response afterwards.
        drive(1, 1'b1, 1'b0, 8'h54, 32'h0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("rst_wait_busy", b_ready, 0);
        b_rst = 1'b1;
        #1;
        chk("rst_wait_resp_valid", b_resp_valid, 0);
        chk("rst_wait_ready",      b_ready, 1);
        chk("rst_wait_enables",    {b_we, b_re}, 2'b00);
        @(negedge clk);
        b_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_resp_valid) cnt++;
        end
        chk("rst_wait_no_resp", cnt, 0);
        chk("rst_wait_rdata",   b_rdata, 32'h0);
        txn(1, 1'b0, 8'h92, 32'h0, 0, 5, 32'h0000_0046, "lat3_ld92");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
